// File: rtl/crack_pkg.sv
// Shared types and sizes for the ARC4 crack scheduler.
//   sched_state_t : scheduler FSM states
//   KEY_W         : default key width
//   CT_ADDR_W     : ciphertext memory address width
//   MAX_CORES     : largest supported engine count
//   IDX_W         : width of an engine index (covers MAX_CORES)
package crack_pkg;

  localparam int unsigned KEY_W     = 24;
  localparam int unsigned CT_ADDR_W = 8;
  localparam int unsigned MAX_CORES = 8;
  localparam int unsigned IDX_W     = $clog2(MAX_CORES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/ct_arbiter.sv
// Ciphertext read-port arbiter: picks one requesting engine per cycle.
// Build option: CRACK_SCHED_RR_EN selects round-robin; otherwise fixed
// priority (lowest index wins).
//   clk, rst_n : clock, synchronous active-low reset
//   active     : arbitration enabled (scheduler in RUN)
//   req        : per-engine read requests
//   gnt_c      : one-hot grant for this cycle (combinational)
//   gnt_any_c  : a grant is issued this cycle
//   gnt_idx_c  : index of this cycle's grant
//   gnt_idx    : registered index of the last grant
//   gnt_vld    : a grant was issued in the previous cycle
module ct_arbiter
  import crack_pkg::*;
#(
  parameter int unsigned NUM_CORES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 active,
  input  logic [NUM_CORES-1:0] req,
  output logic [NUM_CORES-1:0] gnt_c,
  output logic                 gnt_any_c,
  output logic [IDX_W-1:0]     gnt_idx_c,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 gnt_vld
);

`ifdef CRACK_SCHED_RR_EN
  logic [IDX_W-1:0] ptr_q;

  // Priority pointer moves just past the engine that was served.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (gnt_any_c) begin
      ptr_q <= (gnt_idx_c == IDX_W'(NUM_CORES - 1)) ? '0 : gnt_idx_c + IDX_W'(1);
    end
  end
`endif

  // Scan engines in priority order and grant the first requester.
  always_comb begin : p_pick
    int cand;
    gnt_c     = '0;
    gnt_any_c = 1'b0;
    gnt_idx_c = '0;
    cand      = 0;
    for (int k = 0; k < int'(NUM_CORES); k++) begin
`ifdef CRACK_SCHED_RR_EN
      cand = (int'(ptr_q) + k) % int'(NUM_CORES);
`else
      cand = k;
`endif
      if (active && !gnt_any_c && req[cand]) begin
        gnt_any_c   = 1'b1;
        gnt_c[cand] = 1'b1;
        gnt_idx_c   = IDX_W'(cand);
      end
    end
  end

  // Remember who was granted so read data can be steered next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
    end else begin
      gnt_vld <= gnt_any_c;
      if (gnt_any_c) begin
        gnt_idx <= gnt_idx_c;
      end
    end
  end

endmodule

// File: rtl/crack_sched.sv
// Launches NUM_CORES ARC4 crack engines over interleaved key spaces, shares
// the ciphertext read port between them and reports the first key found or
// exhaustion of the key space.
// Build option: CRACK_SCHED_RR_EN (round-robin read arbitration).
//   clk, rst_n      : clock, synchronous active-low reset
//   en / rdy        : start request / idle handshake
//   key, key_valid  : search result
//   ct_addr         : ciphertext memory address (follows the grant)
//   ct_rddata       : ciphertext memory data, one-cycle latency
//   core_en         : one-cycle start pulse to every engine
//   core_rdy        : per-engine idle
//   core_key_base   : engine i starts at key i
//   core_key_stride : key increment (NUM_CORES)
//   core_key        : per-engine found key
//   core_key_valid  : per-engine success, meaningful when idle
//   core_ct_req/addr: per-engine read request and address
//   core_ct_gnt     : one-hot read grant
//   core_ct_valid   : one-hot read data valid, one cycle after grant
//   core_ct_rddata  : read data broadcast to all engines
module crack_sched
  import crack_pkg::*;
#(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned KEY_W     = crack_pkg::KEY_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  output logic                           rdy,
  output logic [KEY_W-1:0]               key,
  output logic                           key_valid,
  output logic [CT_ADDR_W-1:0]           ct_addr,
  input  logic [CT_ADDR_W-1:0]           ct_rddata,
  output logic [NUM_CORES-1:0]           core_en,
  input  logic [NUM_CORES-1:0]           core_rdy,
  output logic [NUM_CORES*KEY_W-1:0]     core_key_base,
  output logic [3:0]                     core_key_stride,
  input  logic [NUM_CORES*KEY_W-1:0]     core_key,
  input  logic [NUM_CORES-1:0]           core_key_valid,
  input  logic [NUM_CORES-1:0]           core_ct_req,
  input  logic [NUM_CORES*CT_ADDR_W-1:0] core_ct_addr,
  output logic [NUM_CORES-1:0]           core_ct_gnt,
  output logic [NUM_CORES-1:0]           core_ct_valid,
  output logic [CT_ADDR_W-1:0]           core_ct_rddata
);

  sched_state_t             state_q, state_d;
  logic [KEY_W-1:0]         key_d;
  logic                     key_valid_d;
  logic [NUM_CORES-1:0]     core_en_d;
  logic [NUM_CORES-1:0]     started_q, started_d;
  logic [NUM_CORES-1:0]     finished_c;
  logic                     match_c;
  logic [KEY_W-1:0]         match_key_c;

  logic                     gnt_any_c;
  logic [IDX_W-1:0]         gnt_idx_c;
  logic [IDX_W-1:0]         gnt_idx;
  logic                     gnt_vld;
  logic [CT_ADDR_W-1:0]     ct_addr_q;

  // Static key-space partitioning: engine i covers i, i+N, i+2N, ...
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_base
    assign core_key_base[i*KEY_W +: KEY_W] = KEY_W'(i);
  end
  assign core_key_stride = 4'(NUM_CORES);

  assign rdy = (state_q == IDLE);

  ct_arbiter #(
    .NUM_CORES (NUM_CORES)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .active    (state_q == RUN),
    .req       (core_ct_req),
    .gnt_c     (core_ct_gnt),
    .gnt_any_c (gnt_any_c),
    .gnt_idx_c (gnt_idx_c),
    .gnt_idx   (gnt_idx),
    .gnt_vld   (gnt_vld)
  );

  // Address goes out in the grant cycle so data returns in the next one;
  // it holds its last value when nobody is granted.
  assign ct_addr = gnt_any_c ? core_ct_addr[int'(gnt_idx_c)*CT_ADDR_W +: CT_ADDR_W]
                             : ct_addr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ct_addr_q <= '0;
    end else if (gnt_any_c) begin
      ct_addr_q <= ct_addr;
    end
  end

  assign core_ct_valid  = gnt_vld ? (NUM_CORES'(1) << gnt_idx) : '0;
  assign core_ct_rddata = ct_rddata;

  // An engine is done only once it has been seen busy since the launch.
  assign finished_c = started_q & core_rdy;

  // Lowest-index finished engine with a valid key wins.
  always_comb begin
    match_c     = 1'b0;
    match_key_c = '0;
    for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
      if (finished_c[i] && core_key_valid[i]) begin
        match_c     = 1'b1;
        match_key_c = core_key[i*KEY_W +: KEY_W];
      end
    end
  end

  // Next-state and register-input logic.
  always_comb begin
    state_d     = state_q;
    key_d       = key;
    key_valid_d = key_valid;
    core_en_d   = '0;
    started_d   = started_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        started_d = '0;
        // Engines left running by a previous search must drain first.
        if (&core_rdy) begin
          core_en_d   = '1;
          key_valid_d = 1'b0;
          state_d     = RUN;
        end
      end
      RUN: begin
        started_d = started_q | ~core_rdy;
        if (match_c) begin
          key_d       = match_key_c;
          key_valid_d = 1'b1;
          state_d     = DONE;
        end else if (&finished_c) begin
          key_valid_d = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      key       <= '0;
      key_valid <= 1'b0;
      core_en   <= '0;
      started_q <= '0;
    end else begin
      state_q   <= state_d;
      key       <= key_d;
      key_valid <= key_valid_d;
      core_en   <= core_en_d;
      started_q <= started_d;
    end
  end

endmodule
